// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the mini CPU pipeline: FSM encoding, hazard-control constants
// and the pipeline-control bundle driven by hazard_ctrl.
package mini_cpu_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned WAIT_W     = 8;
    localparam int unsigned CNT_W      = 16;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [WAIT_W-1:0]     TIMEOUT  = 8'd255;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic pc_hold;
        logic if_id_hold;
        logic if_id_flush;
        logic id_ex_valid;
        logic id_ex_flush;
        logic ex_mem_valid;
        logic mem_wb_flush;
    } pipe_ctrl_t;

    // Full freeze of the front end while data memory is busy; MEM/WB gets a bubble.
    localparam pipe_ctrl_t CTRL_STALL = pipe_ctrl_t'(7'b1100001);

    // Control when memory is not stalling: redirect beats load-use, otherwise flow.
    function automatic pipe_ctrl_t ctrl_flow(input logic redirect, input logic load_use);
        pipe_ctrl_t c;
        c              = '0;
        c.id_ex_valid  = 1'b1;
        c.ex_mem_valid = 1'b1;
        if (redirect) begin
            c.if_id_flush = 1'b1;
            c.id_ex_flush = 1'b1;
        end else if (load_use) begin
            c.pc_hold     = 1'b1;
            c.if_id_hold  = 1'b1;
            c.id_ex_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16
    import mini_cpu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch redirect flush and data-memory
// wait handling with a watchdog that parks the pipeline in ERROR on a stuck access.
module hazard_ctrl
    import mini_cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_redirect,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_hold,
    output logic                  if_id_hold,
    output logic                  if_id_flush,
    output logic                  id_ex_valid,
    output logic                  id_ex_flush,
    output logic                  ex_mem_valid,
    output logic                  mem_wb_flush,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count,
    output logic [1:0]            state
);

    hz_state_e         r_state;
    hz_state_e         w_state_next;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_next;
    logic              r_mem_timeout;
    logic              w_load_use;
    logic              w_mem_stall;
    pipe_ctrl_t        w_ctrl;

    assign w_load_use = ex_mem_read && (ex_rd_addr != REG_ZERO) &&
                        ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                         (id_rs2_used && (id_rs2_addr == ex_rd_addr)));
    assign w_mem_stall = mem_req && !mem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
            if (w_state_next == ST_ERROR) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    // Mealy control: outputs react to this cycle's hazards; reset forces all-zero control.
    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait_cnt;
        w_ctrl       = '0;
        if (!reset) begin
            unique case (r_state)
                ST_RUN: begin
                    if (w_mem_stall) begin
                        w_ctrl       = CTRL_STALL;
                        w_state_next = ST_MEM_WAIT;
                        w_wait_next  = '0;
                    end else begin
                        w_ctrl = ctrl_flow(ex_redirect, w_load_use);
                    end
                end
                ST_MEM_WAIT: begin
                    if (!mem_ready) begin
                        // EX is frozen, so a pending redirect waits for the access to finish.
                        w_ctrl = CTRL_STALL;
                        if (r_wait_cnt == TIMEOUT) begin
                            w_state_next = ST_ERROR;
                        end else begin
                            w_wait_next = r_wait_cnt + WAIT_W'(1);
                        end
                    end else begin
                        w_ctrl       = ctrl_flow(ex_redirect, w_load_use);
                        w_state_next = ST_RUN;
                    end
                end
                ST_ERROR: begin
                    w_ctrl = CTRL_STALL;
                end
                default: begin
                    w_ctrl       = CTRL_STALL;
                    w_state_next = ST_ERROR;
                end
            endcase
        end
    end

    sat_counter16 u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_ctrl.pc_hold),
        .count (stall_cycles)
    );

    sat_counter16 u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_ctrl.if_id_flush),
        .count (flush_count)
    );

    assign pc_hold      = w_ctrl.pc_hold;
    assign if_id_hold   = w_ctrl.if_id_hold;
    assign if_id_flush  = w_ctrl.if_id_flush;
    assign id_ex_valid  = w_ctrl.id_ex_valid;
    assign id_ex_flush  = w_ctrl.id_ex_flush;
    assign ex_mem_valid = w_ctrl.ex_mem_valid;
    assign mem_wb_flush = w_ctrl.mem_wb_flush;
    assign mem_timeout  = r_mem_timeout;
    assign state        = 2'(r_state);

endmodule
